// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART TX scheduler and the command encoders feeding it.
package uart_sched_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } tx_state_t;

  // Command-byte prefixes, agreed with the command encoder
  localparam logic [2:0] CMD_NOP    = 3'b000;
  localparam logic [2:0] CMD_KEY    = 3'b001;
  localparam logic [2:0] CMD_MENU   = 3'b010;
  localparam logic [2:0] CMD_MOUSE  = 3'b011;
  localparam logic [2:0] CMD_REPEAT = 3'b100;
  localparam logic [2:0] CMD_ECHO   = 3'b101;
  localparam logic [2:0] CMD_STATUS = 3'b110;
endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester handshake, flush and transmitter-side signals of the UART TX scheduler.
interface uart_tx_scheduler_if
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int FIFO_DEPTH = 4
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           flush;
  logic                           tx_busy;
  logic                           tx_start;
  logic [BYTE_W-1:0]              tx_data;
  logic [$clog2(FIFO_DEPTH):0]    fifo_level;
  logic                           tx_lost;

  modport master (
    output req_valid, req_data, flush, tx_busy,
    input  req_ready, tx_start, tx_data, fifo_level, tx_lost
  );
  modport slave (
    input  req_valid, req_data, flush, tx_busy,
    output req_ready, tx_start, tx_data, fifo_level, tx_lost
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search just after the last winner.
module rr_arbiter #(
  parameter int NUM_REQ = 3
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);
  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] last;
  int            sel;

  // Lowest index above last wins; otherwise wrap to the lowest index at or below it
  always_comb begin
    sel = -1;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (valid[k] && k <= int'(last)) sel = k;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (valid[k] && k > int'(last)) sel = k;
  end

  always_comb begin
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++)
      grant[k] = en && (sel == k);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                last <= IW'(NUM_REQ - 1);
    else if (en && sel >= 0)  last <= IW'(sel);
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates command bytes from several sources into a FIFO and paces them into one UART transmitter.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 4
)(
  input logic                clk,
  input logic                reset,
  uart_tx_scheduler_if.slave bus
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int LW   = PW + 1;
  localparam int TMAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  logic [BYTE_W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]      head, tail;
  logic [LW-1:0]      level;
  logic [NUM_REQ-1:0] grant;
  logic [BYTE_W-1:0]  push_data, tx_data_q;
  logic               arb_en, push, pop;
  tx_state_t          state, nxt;
  logic [TW-1:0]      tmr, tmr_nxt;
  logic               load, lost_set, lost;

  // Full is judged on the registered level, so a same-cycle pop never frees a slot early
  assign arb_en = !reset && !bus.flush && (level < LW'(FIFO_DEPTH));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .reset (reset),
    .valid (bus.req_valid),
    .en    (arb_en),
    .grant (grant)
  );

  always_comb begin
    push_data = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (grant[k]) push_data = bus.req_data[k];
  end

  assign push = |grant;
  assign pop  = (state == S_START) && (level != '0);

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_comb begin
    nxt      = state;
    tmr_nxt  = tmr;
    load     = 1'b0;
    lost_set = 1'b0;
    case (state)
      S_IDLE:
        if (level != '0 && !bus.tx_busy && !bus.flush) begin
          nxt  = S_START;
          load = 1'b1;
        end
      S_START: begin
        nxt     = S_WAIT_BUSY;
        tmr_nxt = '0;
      end
      S_WAIT_BUSY:
        if (bus.tx_busy) begin
          nxt = S_WAIT_DONE;
        end else if (tmr == TW'(BUSY_TIMEOUT - 1)) begin
          lost_set = 1'b1;
          nxt      = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          tmr_nxt  = '0;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      S_WAIT_DONE:
        if (!bus.tx_busy) begin
          nxt     = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          tmr_nxt = '0;
        end
      S_GAP:
        if (tmr == TW'(GAP_CYCLES - 1)) nxt = S_IDLE;
        else                            tmr_nxt = tmr + 1'b1;
      default: nxt = S_IDLE;
    endcase
  end

  // tx_data is captured on the way into START so it is already valid with the start pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tmr       <= '0;
      tx_data_q <= '0;
      lost      <= 1'b0;
    end else begin
      state <= nxt;
      tmr   <= tmr_nxt;
      if (load)     tx_data_q <= mem[head];
      if (lost_set) lost      <= 1'b1;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.tx_start   = (state == S_START);
  assign bus.tx_data    = tx_data_q;
  assign bus.fifo_level = level;
  assign bus.tx_lost    = lost;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench for uart_tx_scheduler against a queue-based reference model.
module tb_uart_tx_scheduler;
  import uart_sched_pkg::*;
  localparam int N = 3, DEPTH = 4, GAP = 16, TMO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.NUM_REQ(N), .FIFO_DEPTH(DEPTH)) bus();
  uart_tx_scheduler #(.NUM_REQ(N), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_chk = 0, n_pass = 0, cyc_n = 0;
  logic [N-1:0] s_ready, m_ready;
  logic s_start, s_lost, s_busy;
  logic [7:0] s_txd, m_front;
  int s_level, m_level;
  bit m_has;
  logic [7:0] m_q[$];
  int m_last = N - 1;
  int busy_mode = 0, busy_cnt = 0, busy_len = 10;
  bit busy_rand = 0;

  // One clock: sample at negedge, derive this cycle's expectations, advance model, drive busy.
  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    s_ready = bus.req_ready; s_start = bus.tx_start; s_txd = bus.tx_data;
    s_level = int'(bus.fifo_level); s_lost = bus.tx_lost; s_busy = bus.tx_busy;
    m_ready = '0;
    m_level = m_q.size();
    m_has = m_q.size() > 0;
    m_front = m_has ? m_q[0] : 8'h00;
    if (!reset && !bus.flush && m_q.size() < DEPTH)
      for (int i = 1; i <= N; i++) begin
        int k = (m_last + i) % N;
        if (m_ready == '0 && bus.req_valid[k]) m_ready[k] = 1'b1;
      end
    if (reset) begin
      m_q.delete(); m_last = N - 1;
    end else if (bus.flush) begin
      m_q.delete();
    end else begin
      if (s_start && m_q.size() > 0) void'(m_q.pop_front());
      for (int k = 0; k < N; k++)
        if (m_ready[k]) begin m_q.push_back(bus.req_data[k]); m_last = k; end
    end
    if (busy_cnt > 0) busy_cnt--;
    if (s_start) busy_cnt = busy_rand ? int'($urandom_range(8, 1)) : busy_len;
    @(posedge clk);
    #1;
    bus.tx_busy = (busy_mode == 2) || (busy_mode == 0 && busy_cnt > 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = '1; bus.flush = 1'b0; bus.tx_busy = 1'b0;
    for (int k = 0; k < N; k++) bus.req_data[k] = 8'($urandom);
    cyc(); cyc();
    n_chk++; if (s_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", s_start); else n_pass++;
    n_chk++; if (s_txd !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", s_txd); else n_pass++;
    n_chk++; if (s_ready !== '0) $display("FAIL reset_req_ready: got %b want 000", s_ready); else n_pass++;
    n_chk++; if (s_level !== 0) $display("FAIL reset_level: got %0d want 0", s_level); else n_pass++;
    n_chk++; if (s_lost !== 1'b0) $display("FAIL reset_tx_lost: got %b want 0", s_lost); else n_pass++;
    bus.req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int t, s, s2;
    logic [7:0] d, b;
    busy_mode = 0; busy_rand = 0; busy_len = 10;
    bus.req_data[1] = 8'hC5; bus.req_valid = 3'b010;
    cyc(); t = cyc_n;
    n_chk++; if (s_ready !== 3'b010) $display("FAIL single_ready: got %b want 010", s_ready); else n_pass++;
    bus.req_valid = '0;
    s = -1; d = 8'h00;
    for (int i = 0; i < 8 && s < 0; i++) begin
      cyc(); if (s_start) begin s = cyc_n; d = s_txd; end
    end
    n_chk++; if (s != t + 2) $display("FAIL single_latency: start at %0d want %0d", s, t + 2); else n_pass++;
    n_chk++; if (d !== 8'hC5) $display("FAIL single_data: got %h want c5", d); else n_pass++;
    b = 8'($urandom); bus.req_data[2] = b; bus.req_valid[2] = 1'b1;
    s2 = -1;
    for (int i = 0; i < 100 && s2 < 0; i++) begin
      cyc(); bus.req_valid &= ~s_ready;
      if (s_start) begin s2 = cyc_n; d = s_txd; end
    end
    // busy high s+1..s+10, falls at s+11, GAP cycles of gap, one IDLE, then START
    n_chk++; if (s2 != s + 11 + GAP + 2) $display("FAIL single_gap: start at %0d want %0d", s2, s + 13 + GAP); else n_pass++;
    n_chk++; if (d !== b) $display("FAIL single_data2: got %h want %h", d, b); else n_pass++;
  endtask

  task automatic test_round_robin();
    int order[$];
    busy_len = 3;
    bus.req_data[0] = 8'h21; bus.req_data[1] = 8'h42; bus.req_data[2] = 8'h83;
    bus.req_valid = '1;
    for (int i = 0; i < 150; i++) begin
      cyc();
      n_chk++; if (s_ready !== m_ready) $display("FAIL rr_grant c%0d: got %b want %b", cyc_n, s_ready, m_ready); else n_pass++;
      if (s_start) begin
        n_chk++; if (!m_has || s_txd !== m_front) $display("FAIL rr_txdata c%0d: got %h want %h", cyc_n, s_txd, m_front); else n_pass++;
        n_chk++; if (s_busy) $display("FAIL rr_start_busy c%0d: start=1 busy=1 want busy=0", cyc_n); else n_pass++;
      end
      for (int k = 0; k < N; k++) if (s_ready[k]) order.push_back(k);
    end
    n_chk++; if (order.size() < 9) $display("FAIL rr_count: %0d grants want >=9", order.size()); else n_pass++;
    for (int i = 0; i < 9 && i < order.size(); i++) begin
      n_chk++; if (order[i] != i % 3) $display("FAIL rr_order #%0d: got %0d want %0d", i, order[i], i % 3); else n_pass++;
    end
    bus.req_valid = '0;
    idle(120);
  endtask

  task automatic test_random();
    busy_rand = 1;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++)
        if (!bus.req_valid[k] && $urandom_range(2, 0) == 0) begin
          bus.req_data[k] = 8'($urandom); bus.req_valid[k] = 1'b1;
        end
      bus.flush = ($urandom_range(39, 0) == 0);
      cyc();
      n_chk++; if (s_ready !== m_ready) $display("FAIL rand_grant c%0d: got %b want %b", cyc_n, s_ready, m_ready); else n_pass++;
      n_chk++; if (s_level != m_level) $display("FAIL rand_level c%0d: got %0d want %0d", cyc_n, s_level, m_level); else n_pass++;
      if (s_start) begin
        n_chk++; if (!m_has || s_txd !== m_front) $display("FAIL rand_txdata c%0d: got %h want %h", cyc_n, s_txd, m_front); else n_pass++;
        n_chk++; if (s_busy) $display("FAIL rand_start_busy c%0d: start=1 busy=1 want busy=0", cyc_n); else n_pass++;
      end
      bus.req_valid &= ~s_ready;
    end
    bus.flush = 1'b0; bus.req_valid = '0; busy_rand = 0;
    idle(150);
  endtask

  task automatic test_fill();
    int to_issue = 5;
    bit seen = 0;
    busy_mode = 2;
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < N; k++)
        if (!bus.req_valid[k] && to_issue > 0) begin
          bus.req_data[k] = 8'($urandom); bus.req_valid[k] = 1'b1; to_issue--;
        end
      cyc();
      n_chk++; if (s_ready !== m_ready) $display("FAIL fill_grant c%0d: got %b want %b", cyc_n, s_ready, m_ready); else n_pass++;
      n_chk++; if (s_level != m_level) $display("FAIL fill_level c%0d: got %0d want %0d", cyc_n, s_level, m_level); else n_pass++;
      bus.req_valid &= ~s_ready;
    end
    n_chk++; if (s_level != DEPTH) $display("FAIL fill_full: level %0d want %0d", s_level, DEPTH); else n_pass++;
    n_chk++; if (bus.req_valid == '0 || s_ready !== '0) $display("FAIL fill_block: ready=%b want 000 with pending", s_ready); else n_pass++;
    busy_cnt = 0; busy_mode = 0; busy_len = 10;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc(); if (s_start) seen = 1;
    end
    n_chk++; if (!seen || s_ready !== '0 || s_level != DEPTH) $display("FAIL fill_pop_cycle: start=%b ready=%b level=%0d want 1/000/4", seen, s_ready, s_level); else n_pass++;
    cyc();
    n_chk++; if (s_ready == '0 || s_level != DEPTH - 1) $display("FAIL fill_after_pop: ready=%b level=%0d want grant/3", s_ready, s_level); else n_pass++;
    bus.req_valid &= ~s_ready;
    cyc();
    n_chk++; if (s_level != DEPTH) $display("FAIL fill_refull: level %0d want %0d", s_level, DEPTH); else n_pass++;
    for (int i = 0; i < 150; i++) begin
      cyc();
      if (s_start) begin
        n_chk++; if (!m_has || s_txd !== m_front) $display("FAIL fill_txdata c%0d: got %h want %h", cyc_n, s_txd, m_front); else n_pass++;
      end
    end
  endtask

  task automatic test_timeout();
    int s2 = -1;
    bit seen = 0;
    busy_mode = 1;
    bus.req_data[0] = 8'($urandom); bus.req_data[1] = 8'($urandom); bus.req_valid = 3'b011;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc(); bus.req_valid &= ~s_ready; if (s_start) seen = 1;
    end
    n_chk++; if (!seen) $display("FAIL tmo_first_start: none within 10 cycles"); else n_pass++;
    for (int i = 1; i <= 30; i++) begin
      cyc(); bus.req_valid &= ~s_ready;
      if (i == 4) begin n_chk++; if (s_lost !== 1'b0) $display("FAIL tmo_early: tx_lost=%b at +4 want 0", s_lost); else n_pass++; end
      if (i == 5) begin n_chk++; if (s_lost !== 1'b1) $display("FAIL tmo_set: tx_lost=%b at +5 want 1", s_lost); else n_pass++; end
      if (s_start && s2 < 0) begin
        s2 = i;
        n_chk++; if (!m_has || s_txd !== m_front) $display("FAIL tmo_txdata: got %h want %h", s_txd, m_front); else n_pass++;
      end
    end
    // four WAIT_BUSY cycles, GAP cycles of gap, one IDLE, then START
    n_chk++; if (s2 != TMO + GAP + 2) $display("FAIL tmo_next: start at +%0d want +%0d", s2, TMO + GAP + 2); else n_pass++;
    n_chk++; if (s_lost !== 1'b1) $display("FAIL tmo_sticky: tx_lost=%b want 1", s_lost); else n_pass++;
    busy_cnt = 0; busy_mode = 0;
    idle(60);
  endtask

  task automatic test_flush();
    bit seen = 0;
    logic [7:0] nb, d = 8'h00;
    busy_len = 10;
    for (int k = 0; k < N; k++) bus.req_data[k] = 8'($urandom);
    bus.req_valid = '1;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc(); bus.req_valid &= ~s_ready; if (s_start) seen = 1;
    end
    cyc(); bus.req_valid &= ~s_ready;
    cyc(); bus.req_valid &= ~s_ready;
    n_chk++; if (s_level != 2) $display("FAIL flush_pre_level: got %0d want 2", s_level); else n_pass++;
    nb = 8'($urandom); bus.req_data[0] = nb; bus.req_valid[0] = 1'b1; bus.flush = 1'b1;
    cyc();
    n_chk++; if (s_ready !== '0) $display("FAIL flush_no_grant: ready=%b want 000", s_ready); else n_pass++;
    bus.flush = 1'b0;
    cyc(); bus.req_valid &= ~s_ready;
    n_chk++; if (s_level != 0) $display("FAIL flush_level: got %0d want 0", s_level); else n_pass++;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cyc(); bus.req_valid &= ~s_ready;
      if (s_start) begin
        seen = 1; d = s_txd;
        n_chk++; if (s_busy) $display("FAIL flush_start_busy: start while busy"); else n_pass++;
      end
    end
    n_chk++; if (!seen || d !== nb) $display("FAIL flush_next_byte: got %h want %h", d, nb); else n_pass++;
    idle(40);
  endtask

  task automatic test_reset_mid();
    int to_issue = 1;
    bit seen = 0;
    logic [7:0] b, d = 8'h00;
    busy_len = 1000;
    for (int k = 0; k < N; k++) bus.req_data[k] = 8'($urandom);
    bus.req_valid = '1;
    for (int i = 0; i < 10; i++) begin
      cyc(); bus.req_valid &= ~s_ready;
      if (to_issue > 0 && !bus.req_valid[0]) begin
        bus.req_data[0] = 8'($urandom); bus.req_valid[0] = 1'b1; to_issue--;
      end
    end
    n_chk++; if (s_level != 3 || !s_busy) $display("FAIL mid_setup: level=%0d busy=%b want 3/1", s_level, s_busy); else n_pass++;
    #3 reset = 1'b1;
    #1;
    n_chk++; if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00) $display("FAIL mid_tx_out: start=%b data=%h want 0/00", bus.tx_start, bus.tx_data); else n_pass++;
    n_chk++; if (bus.fifo_level !== '0) $display("FAIL mid_level: got %0d want 0", bus.fifo_level); else n_pass++;
    n_chk++; if (bus.req_ready !== '0) $display("FAIL mid_ready: got %b want 000", bus.req_ready); else n_pass++;
    n_chk++; if (bus.tx_lost !== 1'b0) $display("FAIL mid_lost: got %b want 0", bus.tx_lost); else n_pass++;
    cyc(); cyc();
    reset = 1'b0;
    busy_cnt = 15;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_chk++; if (s_start || s_level != 0) $display("FAIL mid_hold c%0d: start=%b level=%0d want 0/0", cyc_n, s_start, s_level); else n_pass++;
    end
    idle(8);
    b = 8'($urandom); bus.req_data[1] = b; bus.req_valid = 3'b010;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc(); bus.req_valid &= ~s_ready;
      if (s_start) begin seen = 1; d = s_txd; end
    end
    n_chk++; if (!seen || d !== b) $display("FAIL mid_resume: start=%b data=%h want 1/%h", seen, d, b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_fill();
    test_timeout();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single UART transmitter between several command sources: button/menu encoder, mouse auto-repeat and host echo. Each source offers one 8-bit command byte at a time. A round-robin arbiter accepts the bytes into a small FIFO. A TX state machine drains the FIFO into the transmitter: one start pulse per byte, a wait for the transmitter's busy flag, and a programmable idle gap between bytes.

Parameters:
NUM_REQ, 3, number of requesters (min 2, max 8)
FIFO_DEPTH, 4, command FIFO depth; power of two, >= 2
GAP_CYCLES, 16, idle clk cycles after busy falls before the next start; 0 = no gap
BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after tx_start

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  requester k has a byte pending; held until accepted
req_data  in  8*NUM_REQ  byte of requester k at bits [8k+7:8k]; stable while valid
req_ready  out  NUM_REQ  one-cycle acceptance pulse, at most one bit set
flush  in  1  synchronous FIFO clear
tx_busy  in  1  transmitter busy flag
tx_start  out  1  one-cycle start pulse to transmitter
tx_data  out  8  byte to transmitter
fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes queued
tx_lost  out  1  sticky: a start got no busy response; cleared only by reset

Behaviour:
- Reset, asynchronous:
  - Outputs: tx_start=0, tx_data=8'h00, req_ready=0, fifo_level=0, tx_lost=0.
  - FIFO pointers 0; round-robin pointer gives requester 0 top priority; FSM=IDLE.
- Acceptance, each cycle:
  - Only if fifo_level < FIFO_DEPTH, using the registered level.
  - Grant the first valid requester searching from (last_grant+1) mod NUM_REQ.
  - req_ready[k]=1 for that cycle; req_data[k] is written to the FIFO tail; last_grant=k.
  - FIFO full: no grant, even if a pop happens in the same cycle.
- TX FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
  - IDLE: fifo_level!=0 and tx_busy=0 -> START.
  - START: tx_start=1 for exactly this cycle; tx_data=FIFO head; pop; -> WAIT_BUSY with timer cleared.
  - WAIT_BUSY: tx_busy=1 -> WAIT_DONE. Otherwise, after BUSY_TIMEOUT cycles set tx_lost=1 -> GAP.
  - WAIT_DONE: tx_busy=0 -> GAP.
  - GAP: count GAP_CYCLES cycles -> IDLE. With GAP_CYCLES=0, WAIT_DONE goes straight to IDLE.
- tx_data: registered; holds its value from START until the next START.
- Push and pop in the same cycle: level unchanged; head and tail pointers both advance, mod FIFO_DEPTH.
- Pop in START with level 1 and a simultaneous push: new byte is queued; level ends at 1.
- flush:
  - Pointers and level go to 0 next cycle; any grant that cycle is suppressed (req_ready=0).
  - FSM is unaffected; a byte already started completes.
- Latency, idle system, tx_busy=0: req_valid rises at cycle t -> req_ready at t -> tx_start at t+2.
- Reset mid-byte: the transmitter finishes on its own; after reset the FSM holds in IDLE until tx_busy=0.
- No combinational path from tx_busy to tx_start.

Decomposition:
- Package uart_sched_pkg:
  - TX FSM state encoding
  - byte width constant (8)
  - command-prefix constants 3'b000..3'b110 shared with the command encoder
- Sub-module rr_arbiter (NUM_REQ parameter): valid vector + enable -> one-hot grant, updates its own priority pointer.
- FIFO and FSM stay inline.

Test Plan:
- Single request: req_valid[1]=1, data 8'hC5, tx_busy=0 → req_ready[1] pulses once; tx_start 2 cycles later with tx_data=8'hC5; model raises busy 10 cycles → next start no earlier than GAP_CYCLES=16 after busy falls.
- All three valid continuously with bytes 8'h21/8'h42/8'h83 → grant order 0,1,2,0,...; TX order matches; tx_start never asserts while tx_busy=1.
- Fill to full: tx_busy held 1, 5 requests → level reaches 4, fifth request not acknowledged until the first pop; level returns to 4.
- Timeout: tx_busy stuck 0 after start → tx_lost=1 after 4 cycles; FSM proceeds to the next byte; tx_lost stays 1.
- Async reset asserted in WAIT_DONE with level 3 → outputs 0 immediately; after release with tx_busy=1, no start until busy falls; queue empty.
- flush with level 2 and a simultaneous req_valid → level 0 next cycle, no req_ready that cycle; the in-flight byte completes normally.
